// File: rtl/divider_128by64.sv
// Sequential unsigned 128/64 restoring divider with divide-by-zero and quotient-overflow flags.
// Optional macro DIV_RADIX4_EN retires two quotient bits per RUN cycle instead of one.
module divider_128by64 #(
    parameter int DIVIDEND_WIDTH = 128,
    parameter int DIVISOR_WIDTH  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] in0,
    input  logic [DIVISOR_WIDTH-1:0]  in1,
    output logic [DIVISOR_WIDTH-1:0]  quot,
    output logic [DIVISOR_WIDTH-1:0]  rem,
    output logic                      busy,
    output logic                      rdy,
    output logic                      dbz,
    output logic                      ovf
);

    localparam int W = DIVISOR_WIDTH;
`ifdef DIV_RADIX4_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam int ITERS = W / STEPS;
    localparam int CW    = $clog2(ITERS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [2*W-1:0]  r_rq;
    logic [W-1:0]    r_div;
    logic [CW-1:0]   r_cnt;

    logic            w_dbz;
    logic            w_ovf;
    logic            w_last;
    logic [2*W-1:0]  w_rq [0:STEPS];

    // One restoring step on {remainder, quotient}; the partial remainder is the
    // top W+1 bits after the shift, so diff[W] is the borrow out of the trial subtract.
    function automatic logic [2*W-1:0] f_step(input logic [2*W-1:0] rq, input logic [W-1:0] d);
        logic [W:0] diff;
        diff = rq[2*W-1:W-1] - {1'b0, d};
        if (!diff[W])
            f_step = {diff[W-1:0], rq[W-2:0], 1'b1};
        else
            f_step = {rq[2*W-2:W-1], rq[W-2:0], 1'b0};
    endfunction

    assign w_dbz  = (in1 == '0);
    assign w_ovf  = (in0[DIVIDEND_WIDTH-1:W] >= in1);
    assign w_last = (r_cnt == '0);
    assign busy   = (r_state == S_RUN);

    assign w_rq[0] = r_rq;
    genvar gi;
    generate
        for (gi = 0; gi < STEPS; gi++) begin : g_step
            assign w_rq[gi+1] = f_step(w_rq[gi], r_div);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start)
                    w_state_next = (w_dbz || w_ovf) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_last)
                    w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rq  <= '0;
            r_div <= '0;
            r_cnt <= '0;
            quot  <= '0;
            rem   <= '0;
            rdy   <= 1'b0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_rq  <= w_rq[STEPS];
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                quot <= w_rq[STEPS][W-1:0];
                rem  <= w_rq[STEPS][2*W-1:W];
                rdy  <= 1'b1;
            end
        end else if (start) begin
            rdy <= 1'b0;
            dbz <= 1'b0;
            ovf <= 1'b0;
            // Exceptions finish on the accepting edge; dbz wins when both apply.
            if (w_dbz) begin
                dbz  <= 1'b1;
                rdy  <= 1'b1;
                quot <= '1;
                rem  <= in0[W-1:0];
            end else if (w_ovf) begin
                ovf  <= 1'b1;
                rdy  <= 1'b1;
                quot <= '1;
                rem  <= '0;
            end else begin
                r_rq  <= in0;
                r_div <= in1;
                r_cnt <= CW'(ITERS - 1);
            end
        end
    end

endmodule

// File: tb/tb_divider_128by64.sv
// Self-checking bench for divider_128by64: directed cases plus random operands
// compared against a plain-arithmetic division model.
module tb_divider_128by64;

`ifdef DIV_RADIX4_EN
    localparam int LAT = 32;
`else
    localparam int LAT = 64;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] in0 = '0;
    logic [63:0]  in1 = '0;
    logic [63:0]  quot, rem;
    logic         busy, rdy, dbz, ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    divider_128by64 #(.DIVIDEND_WIDTH(128), .DIVISOR_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .in0(in0), .in1(in1),
        .quot(quot), .rem(rem), .busy(busy), .rdy(rdy), .dbz(dbz), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [127:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic d, output logic o, output int lat);
        if (b == 64'd0) begin
            q = '1; r = a[63:0]; d = 1'b1; o = 1'b0; lat = 0;
        end else if (a[127:64] >= b) begin
            q = '1; r = '0; d = 1'b0; o = 1'b1; lat = 0;
        end else begin
            q = 64'(a / {64'd0, b});
            r = 64'(a % {64'd0, b});
            d = 1'b0; o = 1'b0; lat = LAT;
        end
    endfunction

    // Counts edges after the accepting edge until rdy is seen (0 = set on the accept edge).
    task automatic wait_rdy(output int lat);
        lat = 0;
        while (rdy !== 1'b1 && lat < LAT + 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic launch(input logic [127:0] a, input logic [63:0] b);
        in0 = a; in1 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [127:0] a, input logic [63:0] b, input int lat);
        logic [63:0] eq, er;
        logic        ed, eo;
        int          elat;
        model(a, b, eq, er, ed, eo, elat);
        chk({tag, ".lat"}, 128'(lat), 128'(elat));
        chk({tag, ".rdy"}, 128'(rdy), 128'(1'b1));
        chk({tag, ".busy"}, 128'(busy), 128'(1'b0));
        chk({tag, ".quot"}, 128'(quot), 128'(eq));
        chk({tag, ".rem"}, 128'(rem), 128'(er));
        chk({tag, ".dbz"}, 128'(dbz), 128'(ed));
        chk({tag, ".ovf"}, 128'(ovf), 128'(eo));
        $display("op %s a=%h b=%h -> quot=%h rem=%h dbz=%b ovf=%b lat=%0d", tag, a, b, quot, rem, dbz, ovf, lat);
    endtask

    task automatic run_op(input string tag, input logic [127:0] a, input logic [63:0] b);
        int lat;
        launch(a, b);
        wait_rdy(lat);
        check_result(tag, a, b, lat);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".quot"}, 128'(quot), 128'd0);
        chk({tag, ".rem"}, 128'(rem), 128'd0);
        chk({tag, ".busy"}, 128'(busy), 128'd0);
        chk({tag, ".rdy"}, 128'(rdy), 128'd0);
        chk({tag, ".dbz"}, 128'(dbz), 128'd0);
        chk({tag, ".ovf"}, 128'(ovf), 128'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a, prod;
        logic [63:0]  b, hi, ca, cb;
        int           lat, mode;

        // Reset held while start is asserted: reset must win.
        rst = 1'b1; in0 = 128'd100; in1 = 64'd7; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        $display("reset: outputs cleared");

        // First edge with rst low accepts immediately.
        rst = 1'b0;
        run_op("div100by7", 128'd100, 64'd7);
        chk("div100by7.q14", 128'(quot), 128'd14);
        chk("div100by7.r2", 128'(rem), 128'd2);

        repeat (5) @(posedge clk);
        #1;
        chk("hold.quot", 128'(quot), 128'd14);
        chk("hold.rem", 128'(rem), 128'd2);
        chk("hold.rdy", 128'(rdy), 128'd1);
        $display("hold: quot=%0d rem=%0d rdy=%b", quot, rem, rdy);

        run_op("shift32", 128'h0000_0000_FFFF_FFFF_0000_0000_0000_0005, 64'h1_0000_0000);
        chk("shift32.qconst", 128'(quot), 128'hFFFF_FFFF_0000_0000);

        a = {$urandom, $urandom, $urandom, $urandom};
        run_op("dbz", a, 64'd0);
        run_op("ovf", 128'h1_0000_0000_0000_0000, 64'd1);
        run_op("ovf_eq", {64'h1234, 64'h9}, 64'h1234);
        run_op("div_by_1", {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 64'd1);
        run_op("max_quot", {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF}, 64'hFFFF_FFFF_FFFF_FFFF);

        ca = 64'hDEAD_BEEF_0123_4567;
        cb = 64'hFEDC_BA98_7654_3211;
        prod = {64'd0, ca} * {64'd0, cb};
        run_op("roundtrip", prod, cb);
        chk("roundtrip.qA", 128'(quot), 128'(ca));
        chk("roundtrip.r0", 128'(rem), 128'd0);

        // Start held high with changing operands while RUN is in progress.
        a = {64'd5, $urandom, $urandom};
        b = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        in0 = a; in1 = b; start = 1'b1;
        @(posedge clk); #1;
        chk("held.busy", 128'(busy), 128'd1);
        for (int i = 0; i < 10; i++) begin
            in0 = {$urandom, $urandom, $urandom, $urandom};
            in1 = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_rdy(lat);
        check_result("held", a, b, lat + 10);

        // Reset in the middle of RUN aborts with nothing delivered.
        launch({64'd3, 64'd12345}, 64'd77);
        repeat (20) @(posedge clk);
        #1;
        chk("abort.busy_before", 128'(busy), 128'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("abort");
        repeat (LAT + 5) @(posedge clk);
        #1;
        chk("abort.no_result", 128'(rdy), 128'd0);
        $display("abort: outputs cleared, no result delivered");
        run_op("after_abort", {64'd3, 64'd12345}, 64'd77);

        for (int n = 0; n < 24; n++) begin
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                b = 64'd0;
                hi = {$urandom, $urandom};
            end else if (mode == 1) begin
                b = {$urandom, $urandom};
                if (b == 64'd0) b = 64'd1;
                hi = b;
            end else begin
                if (mode < 6) b = {$urandom, $urandom};
                else          b = 64'($urandom_range(1, 1000));
                if (b == 64'd0) b = 64'd1;
                hi = {$urandom, $urandom} % b;
            end
            a = {hi, $urandom, $urandom};
            run_op($sformatf("rand%0d", n), a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
